sb_cfg_switchbox: RTL and testbench

SB_CFG_SWITCHBOX -- requirements
Module: sb_cfg_switchbox

---
 rtl/sb_cfg_switchbox_pkg.sv | 26 ++
 rtl/sb_sel4.sv | 25 ++
 rtl/sb_cfg_switchbox.sv | 134 +++++++++++++
 tb/tb_sb_cfg_switchbox.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sb_cfg_switchbox_pkg.sv
// Shared definitions for the configurable switchbox: select encoding,
// configuration load-state enum and a helper that locates a select field.
package sb_cfg_switchbox_pkg;

    // Per-bit select codes: pick the first/second/third of the other sides,
    // or disable the track.
    localparam logic [1:0] SEL_A   = 2'd0;
    localparam logic [1:0] SEL_B   = 2'd1;
    localparam logic [1:0] SEL_C   = 2'd2;
    localparam logic [1:0] SEL_OFF = 2'd3;

    // Configuration loader state; always consistent with the bit count.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,   // no bits collected
        ST_LOAD = 2'd1,   // partial frame collected
        ST_FULL = 2'd2    // complete frame ready to commit
    } load_state_e;

    // MSB index of the 2-bit select for output side `side` (0-based), bit
    // `bit_idx`, in a frame of 8*w bits. Output 1 bit 0 sits at the top so the
    // first bit shifted in lands in the first field.
    function automatic int sel_msb(input int side, input int bit_idx, input int w);
        return 8*w - 1 - 2*(side*w + bit_idx);
    endfunction

endpackage

// File: rtl/sb_sel4.sv
// One output bit of the switchbox: chooses one of three same-index input bits,
// or drives 0 when the track is disabled.
module sb_sel4
    import sb_cfg_switchbox_pkg::*;
(
    input  logic       a_i,
    input  logic       b_i,
    input  logic       c_i,
    input  logic [1:0] sel_i,
    output logic       y_o
);

    // Plain 3:1 mux with a forced-zero code for the disabled track.
    always_comb begin
        y_o = 1'b0;
        case (sel_i)
            SEL_A:   y_o = a_i;
            SEL_B:   y_o = b_i;
            SEL_C:   y_o = c_i;
            SEL_OFF: y_o = 1'b0;
            default: y_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/sb_cfg_switchbox.sv
// Four-sided configurable switchbox. A serially loaded shadow frame is copied
// to the active configuration only on a commit of a complete frame, so the
// routing never sees a partially loaded pattern.
module sb_cfg_switchbox
    import sb_cfg_switchbox_pkg::*;
#(
    parameter int W       = 4,
    parameter int OUT_REG = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] in1,
    input  logic [W-1:0] in2,
    input  logic [W-1:0] in3,
    input  logic [W-1:0] in4,
    output logic [W-1:0] out1,
    output logic [W-1:0] out2,
    output logic [W-1:0] out3,
    output logic [W-1:0] out4,
    input  logic         cfg_en,
    input  logic         cfg_din,
    input  logic         cfg_commit,
    output logic         cfg_ack,
    output logic         cfg_err,
    output logic         cfg_full
);

    localparam int CFG_BITS = 8*W;
    localparam int CNT_W    = $clog2(CFG_BITS + 1);

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CFG_BITS - 1);

    logic [CFG_BITS-1:0] shadow_q;
    logic [CFG_BITS-1:0] active_q;
    logic [CNT_W-1:0]    cnt_q;
    load_state_e         state_q;
    logic                ack_q;
    logic                err_q;

    // Loader FSM: shift/count the shadow frame, accept or reject commits and
    // raise one-cycle ack/err pulses. Commit takes priority over a shift.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q <= '0;
            active_q <= '1;
            cnt_q    <= '0;
            state_q  <= ST_IDLE;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
            if (cfg_commit) begin
                if (state_q == ST_FULL) begin
                    active_q <= shadow_q;
                    ack_q    <= 1'b1;
                end else begin
                    err_q    <= 1'b1;
                end
                cnt_q   <= '0;
                state_q <= ST_IDLE;
            end else if (cfg_en) begin
                // The shadow always keeps the most recent CFG_BITS bits.
                shadow_q <= {shadow_q[CFG_BITS-2:0], cfg_din};
                case (state_q)
                    ST_FULL: begin
                        err_q <= 1'b1;
                    end
                    default: begin
                        cnt_q   <= cnt_q + CNT_ONE;
                        state_q <= (cnt_q == CNT_LAST) ? ST_FULL : ST_LOAD;
                    end
                endcase
            end
        end
    end

    assign cfg_ack  = ack_q;
    assign cfg_err  = err_q;
    assign cfg_full = (state_q == ST_FULL);

    // Side inputs gathered so each output can index "the other three".
    logic [W-1:0]   side_in [4];
    logic [4*W-1:0] mux_d;
    logic [4*W-1:0] out_bus;

    assign side_in[0] = in1;
    assign side_in[1] = in2;
    assign side_in[2] = in3;
    assign side_in[3] = in4;

    // One selector per output bit; its three candidates are the other sides
    // in ascending order.
    for (genvar k = 0; k < 4; k++) begin : g_side
        localparam int SA = (k == 0) ? 1 : 0;
        localparam int SB = (k <= 1) ? 2 : 1;
        localparam int SC = (k <= 2) ? 3 : 2;
        for (genvar b = 0; b < W; b++) begin : g_bit
            localparam int HI = sel_msb(k, b, W);
            sb_sel4 u_sel (
                .a_i   (side_in[SA][b]),
                .b_i   (side_in[SB][b]),
                .c_i   (side_in[SC][b]),
                .sel_i (active_q[HI -: 2]),
                .y_o   (mux_d[k*W + b])
            );
        end
    end

    if (OUT_REG != 0) begin : g_out_reg
        logic [4*W-1:0] out_q;

        // Output register: one cycle of latency from inputs to outputs.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                out_q <= '0;
            end else begin
                out_q <= mux_d;
            end
        end

        assign out_bus = out_q;
    end else begin : g_out_comb
        // Reset forces every select to the disabled code, so this reads 0.
        assign out_bus = mux_d;
    end

    assign out1 = out_bus[0*W +: W];
    assign out2 = out_bus[1*W +: W];
    assign out3 = out_bus[2*W +: W];
    assign out4 = out_bus[3*W +: W];

endmodule

// File: tb/tb_sb_cfg_switchbox.sv
// Bench for sb_cfg_switchbox (W=4, registered outputs): directed scenarios
// followed by randomized traffic, all compared against a behavioural model.
module tb_sb_cfg_switchbox;

    localparam int W = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [3:0] in1 = '0, in2 = '0, in3 = '0, in4 = '0;
    logic [3:0] out1, out2, out3, out4;
    logic       cfg_en = 1'b0, cfg_din = 1'b0, cfg_commit = 1'b0;
    logic       cfg_ack, cfg_err, cfg_full;

    sb_cfg_switchbox #(.W(W), .OUT_REG(1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in1        (in1),
        .in2        (in2),
        .in3        (in3),
        .in4        (in4),
        .out1       (out1),
        .out2       (out2),
        .out3       (out3),
        .out4       (out4),
        .cfg_en     (cfg_en),
        .cfg_din    (cfg_din),
        .cfg_commit (cfg_commit),
        .cfg_ack    (cfg_ack),
        .cfg_err    (cfg_err),
        .cfg_full   (cfg_full)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;
    string phase = "init";

    // Reference model state
    logic [31:0] m_shadow;
    logic [31:0] m_active;
    int          m_cnt;
    logic        m_ack, m_err;
    logic [15:0] m_out;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s/%s observed=%0h expected=%0h", phase, tag, obs, exp);
        end
    endtask

    // Routing rule: select s (0..2) picks the s-th of the other sides in
    // ascending order, select 3 gives 0. Result packed {out4,out3,out2,out1}.
    function automatic logic [15:0] ref_mux(input logic [31:0] act,
                                            input logic [3:0] i1, input logic [3:0] i2,
                                            input logic [3:0] i3, input logic [3:0] i4);
        logic [3:0]  ins [4];
        logic [15:0] r;
        int          sel, n;
        ins[0] = i1; ins[1] = i2; ins[2] = i3; ins[3] = i4;
        r = '0;
        for (int k = 0; k < 4; k++) begin
            for (int b = 0; b < 4; b++) begin
                sel = int'((act >> (30 - 2*(k*4 + b))) & 32'd3);
                n = 0;
                for (int s = 0; s < 4; s++) begin
                    if (s != k) begin
                        if (n == sel) r[k*4 + b] = ins[s][b];
                        n++;
                    end
                end
            end
        end
        return r;
    endfunction

    task automatic model_reset();
        m_shadow = '0;
        m_active = '1;
        m_cnt    = 0;
        m_ack    = 1'b0;
        m_err    = 1'b0;
        m_out    = '0;
    endtask

    task automatic check_all();
        chk("out",  32'({out4, out3, out2, out1}), 32'(m_out));
        chk("ack",  32'(cfg_ack),  32'(m_ack));
        chk("err",  32'(cfg_err),  32'(m_err));
        chk("full", 32'(cfg_full), 32'(m_cnt == 32));
    endtask

    // One clock: drive controls, advance the model, then sample 1ns after the edge.
    task automatic cycle(input bit en, input bit din, input bit commit);
        cfg_en = en; cfg_din = din; cfg_commit = commit;
        m_out = ref_mux(m_active, in1, in2, in3, in4);
        m_ack = 1'b0;
        m_err = 1'b0;
        if (commit) begin
            if (m_cnt == 32) begin
                m_active = m_shadow;
                m_ack = 1'b1;
            end else begin
                m_err = 1'b1;
            end
            m_cnt = 0;
        end else if (en) begin
            m_shadow = {m_shadow[30:0], din};
            if (m_cnt == 32) m_err = 1'b1;
            else m_cnt++;
        end
        @(posedge clk);
        #1;
        check_all();
        cfg_en = 1'b0; cfg_din = 1'b0; cfg_commit = 1'b0;
    endtask

    task automatic shift_word(input logic [31:0] w, input int nbits);
        for (int i = nbits - 1; i >= 0; i--) cycle(1'b1, w[i], 1'b0);
    endtask

    task automatic rand_ins();
        in1 = 4'($urandom); in2 = 4'($urandom); in3 = 4'($urandom); in4 = 4'($urandom);
    endtask

    initial begin
        logic [31:0] w;
        model_reset();

        // Reset state: outputs and flags cleared immediately, inputs ignored.
        phase = "reset";
        in1 = 4'hF; in2 = 4'hF; in3 = 4'hF; in4 = 4'hF;
        #2 rst_n = 1'b0;
        #1;
        check_all();
        for (int i = 0; i < 3; i++) begin
            rand_ins();
            @(posedge clk);
            #1;
            check_all();
        end
        rst_n = 1'b1;

        // Freshly reset: every track disabled, toggling inputs keeps outputs 0.
        phase = "idle_off";
        for (int i = 0; i < 4; i++) begin
            rand_ins();
            cycle(1'b0, 1'b0, 1'b0);
        end

        // All-zero frame: every output takes its first candidate.
        phase = "frame0";
        shift_word(32'h0000_0000, 32);
        cycle(1'b0, 1'b0, 1'b1);
        chk("ack_pulse", 32'(cfg_ack), 32'd1);
        in1 = 4'h5; in2 = 4'hA; in3 = 4'h0; in4 = 4'h0;
        cycle(1'b0, 1'b0, 1'b0);
        chk("out1", 32'(out1), 32'hA);
        chk("out2", 32'(out2), 32'h5);
        chk("out3", 32'(out3), 32'h5);
        chk("out4", 32'(out4), 32'h5);
        chk("ack_gone", 32'(cfg_ack), 32'd0);

        // Mixed frame: out1<-in3, out2<-in4, out3 off, out4<-in1.
        phase = "frame55";
        shift_word(32'h55AA_FF00, 32);
        chk("full_set", 32'(cfg_full), 32'd1);
        cycle(1'b0, 1'b0, 1'b1);
        in1 = 4'h3; in2 = 4'hC; in3 = 4'h9; in4 = 4'h6;
        cycle(1'b0, 1'b0, 1'b0);
        chk("out1", 32'(out1), 32'h9);
        chk("out2", 32'(out2), 32'h6);
        chk("out3", 32'(out3), 32'h0);
        chk("out4", 32'(out4), 32'h3);

        // Short frame: commit rejected, routing unchanged, count cleared.
        phase = "short";
        shift_word($urandom, 20);
        cycle(1'b0, 1'b0, 1'b1);
        chk("err_pulse", 32'(cfg_err), 32'd1);
        chk("no_ack", 32'(cfg_ack), 32'd0);
        cycle(1'b0, 1'b0, 1'b0);
        chk("out1_kept", 32'(out1), 32'h9);
        chk("out4_kept", 32'(out4), 32'h3);
        chk("full_clr", 32'(cfg_full), 32'd0);

        // Overflow: 33rd bit flags an error, frame keeps the last 32 bits.
        phase = "overflow";
        w = $urandom;
        cycle(1'b1, 1'b1, 1'b0);
        shift_word(w, 32);
        chk("err33", 32'(cfg_err), 32'd1);
        chk("full33", 32'(cfg_full), 32'd1);
        cycle(1'b0, 1'b0, 1'b1);
        chk("ack", 32'(cfg_ack), 32'd1);
        rand_ins();
        cycle(1'b0, 1'b0, 1'b0);
        chk("out_last32", 32'({out4, out3, out2, out1}), 32'(ref_mux(w, in1, in2, in3, in4)));

        // Commit with a simultaneous shift bit: the shift is dropped.
        phase = "commit_en";
        shift_word($urandom, 32);
        cycle(1'b1, 1'b1, 1'b1);
        cycle(1'b0, 1'b0, 1'b0);
        chk("full_after", 32'(cfg_full), 32'd0);

        // Reset mid-load: outputs clear at once, next full frame commits.
        phase = "midreset";
        in1 = 4'hF; in2 = 4'hF; in3 = 4'hF; in4 = 4'hF;
        shift_word($urandom, 16);
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all();
        @(posedge clk);
        #1;
        check_all();
        rst_n = 1'b1;
        shift_word($urandom, 32);
        cycle(1'b0, 1'b0, 1'b1);
        chk("ack_after_rst", 32'(cfg_ack), 32'd1);
        rand_ins();
        cycle(1'b0, 1'b0, 1'b0);

        // Randomized traffic.
        phase = "random";
        for (int i = 0; i < 700; i++) begin
            rand_ins();
            cycle($urandom_range(0, 99) < 85, 1'($urandom), $urandom_range(0, 99) < 3);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
